// File: rtl/seq_checker.sv
// Round checker: compares one-hot key presses against the expected pattern.
// Reports pass, wrong key, multiple keys or timeout, with exp_idx tracking.
module seq_checker #(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] round_len,
  input  logic [3:0] user_sel,
  input  logic       button_pressed,
  input  logic [3:0] exp_sel,
  output logic [3:0] exp_idx,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [1:0] fail_code
);

  localparam int CW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [4:0] MAX_L = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE_PASS,
    DONE_FAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [4:0]    len;
  logic [4:0]    len_in;
  logic          prev_pressed;
  logic          press;
  logic          one_hot;
  logic          last;

  assign len_in  = (round_len > MAX_L) ? MAX_L : round_len;
  assign press   = button_pressed & ~prev_pressed;
  assign one_hot = (user_sel != 4'd0) &&
                   ((user_sel & (user_sel - 4'd1)) == 4'd0);
  assign last    = ({1'b0, exp_idx} == (len - 5'd1));
  // saturating increment so the counter can never wrap
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      exp_idx      <= 4'd0;
      cnt          <= '0;
      len          <= 5'd0;
      fail_code    <= 2'd0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      prev_pressed <= 1'b1;
    end else begin
      prev_pressed <= button_pressed;
      pass         <= (state == DONE_PASS);
      fail         <= (state == DONE_FAIL);
      unique case (state)
        IDLE: begin
          if (start) begin
            exp_idx   <= 4'd0;
            cnt       <= '0;
            fail_code <= 2'd0;
            len       <= len_in;
            state     <= (len_in == 5'd0) ? DONE_PASS
                                          : WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          // a press in the timeout cycle wins over the timeout
          if (press) begin
            if (!one_hot) begin
              fail_code <= 2'd2;
              state     <= DONE_FAIL;
            end else if (user_sel != exp_sel) begin
              fail_code <= 2'd1;
              state     <= DONE_FAIL;
            end else begin
              state <= WAIT_RELEASE;
            end
          end else if (cnt_inc == T_LAST) begin
            fail_code <= 2'd3;
            state     <= DONE_FAIL;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_RELEASE: begin
          if (!button_pressed) begin
            if (last) begin
              state <= DONE_PASS;
            end else begin
              exp_idx <= exp_idx + 4'd1;
              cnt     <= '0;
              state   <= WAIT_PRESS;
            end
          end
        end
        DONE_PASS: state <= IDLE;
        DONE_FAIL: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with TIMEOUT_CYC = 10.
// Expected values are hand-computed per scenario.
module tb_seq_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] round_len;
  logic [3:0] user_sel;
  logic       button_pressed;
  logic [3:0] exp_sel;
  logic [3:0] exp_idx;
  logic       busy;
  logic       pass;
  logic       fail;
  logic [1:0] fail_code;

  logic [3:0] pat [16];
  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign exp_sel = pat[exp_idx];

  seq_checker #(
    .MAX_LEN    (16),
    .TIMEOUT_CYC(10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .round_len     (round_len),
    .user_sel      (user_sel),
    .button_pressed(button_pressed),
    .exp_sel       (exp_sel),
    .exp_idx       (exp_idx),
    .busy          (busy),
    .pass          (pass),
    .fail          (fail),
    .fail_code     (fail_code)
  );

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] s);
    user_sel       = s;
    button_pressed = |s;
    step();
  endtask

  task automatic rel();
    user_sel       = 4'd0;
    button_pressed = 1'b0;
    step();
  endtask

  task automatic go(input logic [4:0] n);
    round_len = n;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) pat[i] = 4'(1 << (i % 4));
    pat[1] = 4'b0100;
    pat[2] = 4'b0010;
    reset          = 1'b1;
    start          = 1'b0;
    round_len      = 5'd0;
    user_sel       = 4'd0;
    button_pressed = 1'b0;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_idx", exp_idx, 0);

    // full correct round
    go(5'd3);
    chk("ok_busy", busy, 1);
    press(4'b0001);
    rel();
    chk("ok_idx1", exp_idx, 1);
    press(4'b0100);
    rel();
    press(4'b0010);
    rel();
    chk("ok_pass_early", pass, 0);
    chk("ok_busy_done", busy, 1);
    step();
    chk("ok_pass", pass, 1);
    chk("ok_busy_low", busy, 0);
    chk("ok_code", fail_code, 0);
    step();
    chk("ok_pass_once", pass, 0);

    // wrong key on second entry
    go(5'd3);
    press(4'b0001);
    rel();
    press(4'b1000);
    step();
    chk("wk_fail", fail, 1);
    chk("wk_code", fail_code, 1);
    chk("wk_idx", exp_idx, 1);
    rel();
    chk("wk_fail_once", fail, 0);
    chk("wk_code_hold", fail_code, 1);

    // two keys at once
    go(5'd3);
    chk("mk_code_clr", fail_code, 0);
    press(4'b0011);
    step();
    chk("mk_fail", fail, 1);
    chk("mk_code", fail_code, 2);
    rel();

    // timeout with no press
    go(5'd3);
    n = 0;
    while (!fail && n < 30) begin
      step();
      n++;
    end
    chk("to_cycles", n, 10);
    chk("to_code", fail_code, 3);

    // press edge in the timeout cycle is evaluated
    go(5'd3);
    repeat (8) step();
    press(pat[0]);
    chk("to9_code", fail_code, 0);
    chk("to9_busy", busy, 1);
    step();
    chk("to9_nofail", fail, 0);
    rel();
    chk("to9_idx", exp_idx, 1);

    // reset while holding a key in WAIT_RELEASE
    press(pat[1]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_idx", exp_idx, 0);
    chk("mr_pass", pass, 0);
    chk("mr_fail", fail, 0);
    chk("mr_code", fail_code, 0);
    step();
    chk("mr_pass2", pass, 0);
    chk("mr_fail2", fail, 0);

    // wrong key held through reset and start is not a press
    user_sel = 4'b1000;
    button_pressed = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    go(5'd3);
    repeat (3) step();
    chk("hk_nofail", fail, 0);
    chk("hk_busy", busy, 1);
    chk("hk_idx0", exp_idx, 0);
    rel();
    press(4'b0001);
    rel();
    chk("hk_idx1", exp_idx, 1);
    do_reset();

    // zero-length round
    go(5'd0);
    chk("z_pass_early", pass, 0);
    chk("z_busy", busy, 1);
    step();
    chk("z_pass", pass, 1);

    // round_len 20 clamps to 16; ignored start mid-round
    go(5'd20);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        round_len = 5'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sb_idx", exp_idx, 5);
        chk("sb_busy", busy, 1);
      end
      press(pat[i]);
      if (i == 15) chk("l20_idx15", exp_idx, 15);
      rel();
    end
    chk("l20_pass_early", pass, 0);
    step();
    chk("l20_pass", pass, 1);
    chk("l20_fail", fail, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
